// File: rtl/mem_debug_dumper_pkg.sv
// Shared types and constants for the memory debug dumper.
package mem_debug_dumper_pkg;

  localparam int unsigned NB_BYTE         = 8;
  localparam int unsigned NB_DATA_DEFAULT = 32;
  localparam int unsigned BYTES_PER_WORD  = NB_DATA_DEFAULT / NB_BYTE;

  typedef enum logic [1:0] {
    StIdle,
    StWaitRd,
    StSend,
    StDone
  } state_e;

  // Bytes per debug word for a given word/byte width pair.
  function automatic int unsigned bytes_per_word(input int unsigned nb_data,
                                                 input int unsigned nb_byte);
    return nb_data / nb_byte;
  endfunction

endpackage

// File: rtl/mem_debug_dumper_if.sv
// Debug-read and byte-stream signals of the memory dumper.
interface mem_debug_dumper_if #(
  parameter int unsigned NB_DATA   = 32,
  parameter int unsigned NB_BYTE   = 8,
  parameter int unsigned NUM_DIREC = 7
);
  logic                 i_start;
  logic [NUM_DIREC-1:0] o_direcc_debug;
  logic [NB_DATA-1:0]   i_data_debug;
  logic [NB_BYTE-1:0]   o_tx_data;
  logic                 o_tx_valid;
  logic                 i_tx_ready;
  logic                 o_busy;
  logic                 o_done;

  // Dumper side: drives the memory address and the byte stream.
  modport master (
    input  i_start, i_data_debug, i_tx_ready,
    output o_direcc_debug, o_tx_data, o_tx_valid, o_busy, o_done
  );

  // Environment side: memory, transmitter and requester.
  modport slave (
    output i_start, i_data_debug, i_tx_ready,
    input  o_direcc_debug, o_tx_data, o_tx_valid, o_busy, o_done
  );
endinterface

// File: rtl/mem_debug_dumper_word_serializer.sv
// Holds one debug word and presents it a byte at a time, LSB first.
module word_serializer #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_BYTE = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [NB_DATA-1:0] word_i,
  input  logic               advance_i,
  output logic [NB_BYTE-1:0] byte_o,
  output logic               last_o
);
  import mem_debug_dumper_pkg::*;

  localparam int unsigned WordBytes = bytes_per_word(NB_DATA, NB_BYTE);
  localparam int unsigned CntW      = (WordBytes > 1) ? $clog2(WordBytes) : 1;

  logic [NB_DATA-1:0] word_q, word_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  // Load restarts at byte 0; advance steps through the word and wraps after the last byte.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      word_d = word_i;
      cnt_d  = '0;
    end else if (advance_i) begin
      cnt_d = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Word and byte counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign byte_o = word_q[cnt_q*NB_BYTE +: NB_BYTE];
  assign last_o = (cnt_q == CntW'(WordBytes - 1));

endmodule

// File: rtl/mem_debug_dumper.sv
// Walks the data memory through its debug read port and streams every byte out.
module mem_debug_dumper #(
  parameter int unsigned NB_DATA   = 32,
  parameter int unsigned NB_BYTE   = mem_debug_dumper_pkg::NB_BYTE,
  parameter int unsigned NUM_SLOTS = 128,
  parameter int unsigned NUM_DIREC = $clog2(NUM_SLOTS)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  mem_debug_dumper_if.master bus_if
);
  import mem_debug_dumper_pkg::*;

  localparam int unsigned          WordBytes = bytes_per_word(NB_DATA, NB_BYTE);
  localparam logic [NUM_DIREC-1:0] AddrStep  = NUM_DIREC'(WordBytes);
  localparam logic [NUM_DIREC-1:0] LastAddr  = NUM_DIREC'(NUM_SLOTS - WordBytes);

  state_e               state_q, state_d;
  logic [NUM_DIREC-1:0] addr_q, addr_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ser_load, ser_advance, ser_last;
  logic [NB_BYTE-1:0]   ser_byte;

  word_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_serializer (
    .clk_i     (i_clock),
    .rst_ni    (i_reset),
    .load_i    (ser_load),
    .word_i    (bus_if.i_data_debug),
    .advance_i (ser_advance),
    .byte_o    (ser_byte),
    .last_o    (ser_last)
  );

  // Next state; outputs are computed one cycle ahead so they come straight from flops.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    tx_valid_d  = tx_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ser_load    = 1'b0;
    ser_advance = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus_if.i_start) begin
          addr_d  = '0;
          busy_d  = 1'b1;
          state_d = StWaitRd;
        end
      end
      // Address has been stable for a full cycle, so the falling-edge read has settled.
      StWaitRd: begin
        ser_load   = 1'b1;
        tx_valid_d = 1'b1;
        state_d    = StSend;
      end
      StSend: begin
        if (tx_valid_q && bus_if.i_tx_ready) begin
          ser_advance = 1'b1;
          if (ser_last) begin
            tx_valid_d = 1'b0;
            if (addr_q == LastAddr) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = StDone;
            end else begin
              addr_d  = addr_q + AddrStep;
              state_d = StWaitRd;
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM, address counter and registered outputs.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus_if.o_direcc_debug = addr_q;
  assign bus_if.o_tx_data      = ser_byte;
  assign bus_if.o_tx_valid     = tx_valid_q;
  assign bus_if.o_busy         = busy_q;
  assign bus_if.o_done         = done_q;

endmodule
